// File: rtl/fifo_level_if.sv
// Handshake and status bundle between a FIFO user and fifo_level.
// The master drives requests and write data; the slave (the FIFO) returns
// head data, occupancy and flags.
interface fifo_level_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         wr;
  logic         rd;
  logic [B-1:0] w_data;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output wr, rd, w_data, clr_err,
    input  r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  wr, rd, w_data, clr_err,
    output r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_level.sv
// Single-clock circular FIFO with show-ahead read data.
// Reports occupancy, programmable almost-full/almost-empty thresholds
// and sticky overflow/underflow error flags. All flags are registered
// and are derived from the next occupancy, so they move with count.
module fifo_level #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_level_if.slave bus
);
  localparam int         D      = 2 ** W;
  localparam logic [W:0] D_CNT  = (W + 1)'(D);
  localparam logic [W:0] AF_CNT = (W + 1)'(AF_LEVEL);
  localparam logic [W:0] AE_CNT = (W + 1)'(AE_LEVEL);

  logic [B-1:0] mem_q [D];

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         a_empty_q, a_empty_d;
  logic         a_full_q, a_full_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         wr_ok, rd_ok;

  // Legality, pointer/count next state, flags from next count, sticky errors
  always_comb begin
    wr_ok   = bus.wr & (~full_q | bus.rd);
    rd_ok   = bus.rd & ~empty_q;
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;

    if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d   = (count_d == '0);
    full_d    = (count_d == D_CNT);
    a_empty_d = (count_d <= AE_CNT);
    a_full_d  = (count_d >= AF_CNT);

    // A rejected access in the same cycle as clr_err keeps its flag set
    ovf_d = (ovf_q & ~bus.clr_err) | (bus.wr & ~wr_ok);
    unf_d = (unf_q & ~bus.clr_err) | (bus.rd & empty_q);
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      a_empty_q <= 1'b1;
      a_full_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      a_empty_q <= a_empty_d;
      a_full_q  <= a_full_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage array; contents survive reset, only pointers are cleared
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[w_ptr_q] <= bus.w_data;
  end

  assign bus.r_data       = mem_q[r_ptr_q];
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = a_empty_q;
  assign bus.almost_full  = a_full_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
